ctr_cnt_seq_dec: RTL and testbench

- Sequenced step counter with a registered one-hot decoded output, for the ctr_time control path.
- Replaces the free-standing combinational count decoder plus an external counter. It owns the count register and provides start/stop/pause control, single-shot or loop mode, and last/done flags.
- Downstream stage controllers take one enable bit per step directly from cnt_dec.

---
 rtl/ctr_cnt_seq_dec.sv | 115 +++++++++++
 tb/tb_ctr_cnt_seq_dec.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ctr_cnt_seq_dec.sv
// Sequenced step counter that owns its count register and presents a registered one-hot step decode.
// Each downstream stage controller takes its enable directly from one cnt_dec bit.
module ctr_cnt_seq_dec #(
    parameter string OUTTER_NAME = "",
    parameter string MODULE_NAME = "ctr_cnt_seq_dec",
    parameter int    CNT_VAL     = 1024,
    parameter int    ZERO_VAL_EN = 0,
    parameter int    LOOP_EN     = 0,
    localparam int   CNT_W       = (CNT_VAL < 1) ? 1 : $clog2(CNT_VAL + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    output logic               busy,
    output logic [CNT_W-1:0]   cnt,
    output logic [CNT_VAL-1:0] cnt_dec,
    output logic               last,
    output logic               done
);

    localparam int FIRST = (ZERO_VAL_EN != 0) ? 0 : 1;
    localparam int LAST  = (ZERO_VAL_EN != 0) ? CNT_VAL - 1 : CNT_VAL;
    localparam logic [CNT_W-1:0] FIRST_C = CNT_W'(FIRST);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LAST);
    localparam logic [CNT_VAL-1:0] DEC_FIRST = CNT_VAL'(1);

    if (CNT_VAL < 1) begin : g_bad_cnt_val
        $error("%s.%s: CNT_VAL must be >= 1", OUTTER_NAME, MODULE_NAME);
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [CNT_VAL-1:0] dec_r, dec_s;
    logic               done_r, done_s;

    // State, count, decode and done registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            dec_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            dec_r   <= dec_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; stop beats start, start beats pause, pause beats advance.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        dec_s   = dec_r;
        done_s  = 1'b0;
        if (stop) begin
            state_s = IDLE;
            cnt_s   = '0;
            dec_s   = '0;
        end else if (start) begin
            state_s = RUN;
            cnt_s   = FIRST_C;
            dec_s   = DEC_FIRST;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RUN: begin
                    if (pause) begin
                        state_s = RUN;
                    end else if (cnt_r == LAST_C) begin
                        // End of run: done pulses whether we loop or return to idle.
                        done_s = 1'b1;
                        if (LOOP_EN != 0) begin
                            state_s = RUN;
                            cnt_s   = FIRST_C;
                            dec_s   = DEC_FIRST;
                        end else begin
                            state_s = IDLE;
                            cnt_s   = '0;
                            dec_s   = '0;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                        dec_s = dec_r << 1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    dec_s   = '0;
                end
            endcase
        end
    end

    // Outputs derived from registered state only.
    always_comb begin
        busy    = (state_r == RUN);
        last    = (state_r == RUN) && (cnt_r == LAST_C);
        cnt     = cnt_r;
        cnt_dec = dec_r;
        done    = done_r;
    end

endmodule

// File: tb/tb_ctr_cnt_seq_dec.sv
// Randomised bench for ctr_cnt_seq_dec: five configurations share one stimulus stream and are
// compared each cycle against a step-index reference model.
module tb_ctr_cnt_seq_dec;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic pause = 1'b0;

    always #5 clk = ~clk;

    localparam int NI = 5;
    int    cv[NI]   = '{4, 4, 4, 1, 1};
    int    ze[NI]   = '{0, 1, 0, 0, 0};
    int    lp[NI]   = '{0, 0, 1, 0, 1};
    string name[NI] = '{"a4", "z4", "l4", "a1", "l1"};

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] o_cnt[NI], o_dec[NI];
    logic        o_busy[NI], o_last[NI], o_done[NI];

    logic [2:0] cnt_a, cnt_z, cnt_l;
    logic [0:0] cnt_b, cnt_m;
    logic [3:0] dec_a, dec_z, dec_l;
    logic [0:0] dec_b, dec_m;

    ctr_cnt_seq_dec #(.OUTTER_NAME("tb"), .MODULE_NAME("u_a"), .CNT_VAL(4), .ZERO_VAL_EN(0), .LOOP_EN(0)) u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .busy(o_busy[0]), .cnt(cnt_a), .cnt_dec(dec_a), .last(o_last[0]), .done(o_done[0]));
    ctr_cnt_seq_dec #(.OUTTER_NAME("tb"), .MODULE_NAME("u_z"), .CNT_VAL(4), .ZERO_VAL_EN(1), .LOOP_EN(0)) u_z (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .busy(o_busy[1]), .cnt(cnt_z), .cnt_dec(dec_z), .last(o_last[1]), .done(o_done[1]));
    ctr_cnt_seq_dec #(.OUTTER_NAME("tb"), .MODULE_NAME("u_l"), .CNT_VAL(4), .ZERO_VAL_EN(0), .LOOP_EN(1)) u_l (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .busy(o_busy[2]), .cnt(cnt_l), .cnt_dec(dec_l), .last(o_last[2]), .done(o_done[2]));
    ctr_cnt_seq_dec #(.OUTTER_NAME("tb"), .MODULE_NAME("u_b"), .CNT_VAL(1), .ZERO_VAL_EN(0), .LOOP_EN(0)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .busy(o_busy[3]), .cnt(cnt_b), .cnt_dec(dec_b), .last(o_last[3]), .done(o_done[3]));
    ctr_cnt_seq_dec #(.OUTTER_NAME("tb"), .MODULE_NAME("u_m"), .CNT_VAL(1), .ZERO_VAL_EN(0), .LOOP_EN(1)) u_m (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .busy(o_busy[4]), .cnt(cnt_m), .cnt_dec(dec_m), .last(o_last[4]), .done(o_done[4]));

    assign o_cnt[0] = 32'(cnt_a);
    assign o_cnt[1] = 32'(cnt_z);
    assign o_cnt[2] = 32'(cnt_l);
    assign o_cnt[3] = 32'(cnt_b);
    assign o_cnt[4] = 32'(cnt_m);
    assign o_dec[0] = 32'(dec_a);
    assign o_dec[1] = 32'(dec_z);
    assign o_dec[2] = 32'(dec_l);
    assign o_dec[3] = 32'(dec_b);
    assign o_dec[4] = 32'(dec_m);

    // Reference model: a run flag plus a 0-based step index; outputs follow from the step rules.
    bit run_m[NI];
    int k_m[NI];
    bit done_m[NI];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            done_m[i] = 1'b0;
            if (rst || stop) begin
                run_m[i] = 1'b0;
                k_m[i]   = 0;
            end else if (start) begin
                run_m[i] = 1'b1;
                k_m[i]   = 0;
            end else if (run_m[i] && !pause) begin
                if (k_m[i] == cv[i] - 1) begin
                    done_m[i] = 1'b1;
                    k_m[i]    = 0;
                    run_m[i]  = (lp[i] != 0);
                end else begin
                    k_m[i] = k_m[i] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            logic [31:0] e_cnt, e_dec;
            int first;
            first = (ze[i] != 0) ? 0 : 1;
            e_cnt = run_m[i] ? 32'(k_m[i] + first) : 32'd0;
            e_dec = run_m[i] ? (32'd1 << k_m[i]) : 32'd0;
            chk({name[i], ".busy"}, 32'(o_busy[i]), 32'(run_m[i]));
            chk({name[i], ".cnt"}, o_cnt[i], e_cnt);
            chk({name[i], ".cnt_dec"}, o_dec[i], e_dec);
            chk({name[i], ".last"}, 32'(o_last[i]), 32'(run_m[i] && (k_m[i] == cv[i] - 1)));
            chk({name[i], ".done"}, 32'(o_done[i]), 32'(done_m[i]));
        end
    endtask

    task automatic cycle(input logic [3:0] v);
        {rst, stop, start, pause} = v;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Directed vectors {rst, stop, start, pause} following the plan scenarios.
    logic [3:0] dir[$] = '{
        4'b1000, 4'b1000, 4'b0000, 4'b0001,
        4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
        4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
        4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000,
        4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000,
        4'b0010, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 4'b0110,
        4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
        4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000
    };

    initial begin
        for (int i = 0; i < NI; i++) begin
            run_m[i]  = 1'b0;
            k_m[i]    = 0;
            done_m[i] = 1'b0;
        end
        foreach (dir[j]) cycle(dir[j]);
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] v;
            v[3] = ($urandom_range(0, 63) == 0);
            v[2] = ($urandom_range(0, 15) == 0);
            v[1] = ($urandom_range(0, 9) == 0);
            v[0] = ($urandom_range(0, 3) == 0);
            cycle(v);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
